track_scheduler: RTL and testbench

Upstream feeder for the pipelined mixer. On each frame tick it walks all `NUM_TRA` tracks in order, reads each track's current sample from the track sample buffer, and attaches that track's attenuation code from a local gain register file. It then presents the beats to the mixer's DSP-side AXI-stream input with a last-track marker. It also flags frame overruns when a tick arrives before the previous frame has drained.

---
 rtl/track_scheduler.sv | 137 +++++++++++++
 tb/tb_track_scheduler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/track_scheduler.sv
// rtl/track_scheduler.sv - per-frame track walker feeding samples plus gain codes to the mixer stream.
// Optional TRACK_MUTE_EN adds a per-track mute mask that forces the beat's ctl to silence.
module track_scheduler #(
  parameter int SAM_WID  = 16,
  parameter int NUM_TRA  = 32,
  parameter int CTL_WID  = 4,
  parameter int ADDR_WID = $clog2(NUM_TRA)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_tick,
  input  logic                gain_we,
  input  logic [ADDR_WID-1:0] gain_addr,
  input  logic [CTL_WID-1:0]  gain_data,
  output logic                buf_rd_en,
  output logic [ADDR_WID-1:0] buf_rd_addr,
  input  logic [SAM_WID-1:0]  buf_rd_data,
  output logic [SAM_WID-1:0]  trk_axi_data,
  output logic [CTL_WID-1:0]  trk_axi_ctl,
  output logic                trk_axi_last,
  output logic                trk_axi_valid,
  input  logic                trk_axi_ready,
  output logic                busy,
  output logic                overrun,
  input  logic                overrun_clr
`ifdef TRACK_MUTE_EN
  ,
  input  logic [NUM_TRA-1:0]  mute
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_SEND  = 2'd3;

  localparam logic [ADDR_WID-1:0] LAST_IDX = ADDR_WID'(NUM_TRA - 1);
  localparam logic [ADDR_WID-1:0] ONE_IDX  = ADDR_WID'(1);

  logic [1:0]          state;
  logic [ADDR_WID-1:0] idx;
  logic [CTL_WID-1:0]  gain [NUM_TRA];
  logic [CTL_WID-1:0]  ctl_sel;
  logic                hs;
  logic                restart;
  logic                tick_ignored;

  assign hs           = trk_axi_valid && trk_axi_ready;
  // A tick landing on the final handshake chains straight into the next frame.
  assign restart      = (state == S_SEND) && hs && trk_axi_last && frame_tick;
  assign tick_ignored = frame_tick && (state != S_IDLE) && !restart;

`ifdef TRACK_MUTE_EN
  assign ctl_sel = mute[idx] ? {CTL_WID{1'b1}} : gain[idx];
`else
  assign ctl_sel = gain[idx];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_TRA; i++) gain[i] <= '0;
    end else if (gain_we) begin
      gain[gain_addr] <= gain_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      idx           <= '0;
      buf_rd_en     <= 1'b0;
      buf_rd_addr   <= '0;
      trk_axi_data  <= '0;
      trk_axi_ctl   <= '0;
      trk_axi_last  <= 1'b0;
      trk_axi_valid <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (frame_tick) begin
            idx         <= '0;
            buf_rd_en   <= 1'b1;
            buf_rd_addr <= '0;
            busy        <= 1'b1;
            state       <= S_FETCH;
          end
        end
        S_FETCH: begin
          buf_rd_en <= 1'b0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          trk_axi_data  <= buf_rd_data;
          trk_axi_ctl   <= ctl_sel;
          trk_axi_last  <= (idx == LAST_IDX);
          trk_axi_valid <= 1'b1;
          state         <= S_SEND;
        end
        S_SEND: begin
          if (hs) begin
            trk_axi_valid <= 1'b0;
            if (!trk_axi_last) begin
              idx         <= idx + ONE_IDX;
              buf_rd_addr <= idx + ONE_IDX;
              buf_rd_en   <= 1'b1;
              state       <= S_FETCH;
            end else if (frame_tick) begin
              idx         <= '0;
              buf_rd_addr <= '0;
              buf_rd_en   <= 1'b1;
              state       <= S_FETCH;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (tick_ignored) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_track_scheduler.sv
// tb/tb_track_scheduler.sv - directed self-checking bench for track_scheduler.
module tb_track_scheduler;

  localparam int SAM_WID  = 16;
  localparam int NUM_TRA  = 32;
  localparam int CTL_WID  = 4;
  localparam int ADDR_WID = 5;

  logic                clk = 1'b0;
  logic                reset;
  logic                frame_tick;
  logic                gain_we;
  logic [ADDR_WID-1:0] gain_addr;
  logic [CTL_WID-1:0]  gain_data;
  logic                buf_rd_en;
  logic [ADDR_WID-1:0] buf_rd_addr;
  logic [SAM_WID-1:0]  buf_rd_data = '0;
  logic [SAM_WID-1:0]  trk_axi_data;
  logic [CTL_WID-1:0]  trk_axi_ctl;
  logic                trk_axi_last;
  logic                trk_axi_valid;
  logic                trk_axi_ready;
  logic                busy;
  logic                overrun;
  logic                overrun_clr;
  logic [NUM_TRA-1:0]  mute = '0;

  int checks = 0;
  int errors = 0;
  int nb;
  logic [CTL_WID-1:0] gm [NUM_TRA];

  track_scheduler #(
    .SAM_WID(SAM_WID), .NUM_TRA(NUM_TRA), .CTL_WID(CTL_WID), .ADDR_WID(ADDR_WID)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .gain_we(gain_we), .gain_addr(gain_addr), .gain_data(gain_data),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
    .trk_axi_data(trk_axi_data), .trk_axi_ctl(trk_axi_ctl), .trk_axi_last(trk_axi_last),
    .trk_axi_valid(trk_axi_valid), .trk_axi_ready(trk_axi_ready),
    .busy(busy), .overrun(overrun), .overrun_clr(overrun_clr)
`ifdef TRACK_MUTE_EN
    , .mute(mute)
`endif
  );

  always #5 clk = ~clk;

  // Sample buffer model: one-cycle read latency, buffer[i] = 0x100 + i.
  always @(posedge clk) begin
    if (buf_rd_en) buf_rd_data <= 16'h0100 + 16'(buf_rd_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [21:0] cur_beat();
    return {trk_axi_valid, trk_axi_last, trk_axi_ctl, trk_axi_data};
  endfunction

  function automatic logic [21:0] beat_exp(input int k);
    logic [4:0] i;
    logic [3:0] c;
    i = k[4:0];
    c = mute[i] ? 4'hF : gm[i];
    return {1'b1, (k == NUM_TRA - 1), c, 16'h0100 + 16'(k)};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic write_gain(input int a, input logic [3:0] d);
    gain_we   = 1'b1;
    gain_addr = a[4:0];
    gain_data = d;
    step();
    gain_we   = 1'b0;
    gm[a]     = d;
  endtask

  // Runs the frame to completion, checking every beat and stall stability.
  task automatic drain(input bit rand_ready, input int first, output int n);
    bit          stall;
    logic [21:0] held;
    stall = 1'b0;
    held  = '0;
    n     = first;
    for (int c = 0; c < 3000 && busy; c++) begin
      if (stall) chk("stall_hold", 32'(cur_beat()), 32'(held));
      trk_axi_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (trk_axi_valid && trk_axi_ready) begin
        chk("beat", 32'(cur_beat()), 32'(beat_exp(n)));
        n++;
        stall = 1'b0;
      end else if (trk_axi_valid) begin
        stall = 1'b1;
        held  = cur_beat();
      end else begin
        stall = 1'b0;
      end
      step();
    end
    chk("drain_done_busy", 32'(busy), 32'd0);
    trk_axi_ready = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NUM_TRA; i++) gm[i] = '0;
    reset = 1'b1; frame_tick = 1'b0; gain_we = 1'b0; gain_addr = '0; gain_data = '0;
    trk_axi_ready = 1'b1; overrun_clr = 1'b0;
    step(); step();
    chk("rst_valid", 32'(trk_axi_valid), 32'd0);
    chk("rst_last", 32'(trk_axi_last), 32'd0);
    chk("rst_rd_en", 32'(buf_rd_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_data", 32'(trk_axi_data), 32'd0);
    chk("rst_ctl", 32'(trk_axi_ctl), 32'd0);
    chk("rst_addr", 32'(buf_rd_addr), 32'd0);
    reset = 1'b0;
    step();

    // Frame with ready high: exact beat timing and gain attachment.
    write_gain(5, 4'h3);
    write_gain(31, 4'hF);
    pulse_tick();
    chk("f1_busy", 32'(busy), 32'd1);
    chk("f1_rd_en", 32'(buf_rd_en), 32'd1);
    chk("f1_addr", 32'(buf_rd_addr), 32'd0);
    for (int k = 0; k < NUM_TRA; k++) begin
      step();
      chk("f1_pre_valid", 32'(trk_axi_valid), 32'd0);
      step();
      chk("f1_beat", 32'(cur_beat()), 32'(beat_exp(k)));
      step();
      if (k < NUM_TRA - 1) chk("f1_next_addr", 32'(buf_rd_addr), 32'(k + 1));
    end
    chk("f1_idle_busy", 32'(busy), 32'd0);
    chk("f1_idle_valid", 32'(trk_axi_valid), 32'd0);
    chk("f1_overrun", 32'(overrun), 32'd0);

    // Random backpressure.
    pulse_tick();
    drain(1'b1, 0, nb);
    chk("f2_beats", 32'(nb), 32'd32);

    // Tick at beat 10 sets overrun, frame completes.
    pulse_tick();
    repeat (32) step();
    chk("f3_beat10", 32'(cur_beat()), 32'(beat_exp(10)));
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    chk("f3_overrun_set", 32'(overrun), 32'd1);
    drain(1'b0, 11, nb);
    chk("f3_beats", 32'(nb), 32'd32);
    chk("f3_overrun_sticky", 32'(overrun), 32'd1);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    chk("f3_overrun_clr", 32'(overrun), 32'd0);

    // Clear with simultaneous ignored tick: set wins.
    pulse_tick();
    step();
    frame_tick = 1'b1;
    overrun_clr = 1'b1;
    step();
    frame_tick = 1'b0;
    overrun_clr = 1'b0;
    chk("f4_set_wins", 32'(overrun), 32'd1);
    drain(1'b0, 0, nb);
    chk("f4_beats", 32'(nb), 32'd32);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;

    // Back-to-back frame on last handshake, then reset at beat 12.
    pulse_tick();
    repeat (2 + 3 * 31) step();
    chk("f5_last_beat", 32'(cur_beat()), 32'(beat_exp(31)));
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    chk("f5_chain_busy", 32'(busy), 32'd1);
    chk("f5_chain_rd_en", 32'(buf_rd_en), 32'd1);
    chk("f5_chain_addr", 32'(buf_rd_addr), 32'd0);
    chk("f5_no_overrun", 32'(overrun), 32'd0);
    repeat (2 + 3 * 12) step();
    chk("f5_beat12", 32'(cur_beat()), 32'(beat_exp(12)));
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(trk_axi_valid), 32'd0);
    chk("mid_rst_last", 32'(trk_axi_last), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rd_en", 32'(buf_rd_en), 32'd0);
    chk("mid_rst_data", 32'(trk_axi_data), 32'd0);
    chk("mid_rst_ctl", 32'(trk_axi_ctl), 32'd0);
    chk("mid_rst_addr", 32'(buf_rd_addr), 32'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < NUM_TRA; i++) gm[i] = '0;
    step();
    pulse_tick();
    chk("f6_addr", 32'(buf_rd_addr), 32'd0);
    drain(1'b0, 0, nb);
    chk("f6_beats", 32'(nb), 32'd32);

`ifdef TRACK_MUTE_EN
    write_gain(2, 4'h1);
    mute = 32'h0000_0004;
    pulse_tick();
    drain(1'b0, 0, nb);
    chk("mute_beats", 32'(nb), 32'd32);
    mute = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
